// File: rtl/cmd_cfg_pkg.sv
// cmd_cfg_pkg: opcodes, response codes and FSM states for the command/config block
package cmd_cfg_pkg;
  localparam logic [7:0] OP_SP_LAST  = 8'h3F;
  localparam logic [7:0] OP_CAL      = 8'h40;
  localparam logic [7:0] OP_EMER     = 8'h41;
  localparam logic [7:0] OP_MTRS_OFF = 8'h42;
  localparam logic [7:0] RESP_ACK    = 8'hA5;
  localparam logic [7:0] RESP_NAK    = 8'h5A;
  typedef enum logic [1:0] {IDLE, CAL_WAIT, RESP, WAIT_SENT} state_t;
  function automatic logic is_set(input logic [7:0] c, input int n);
    return c <= OP_SP_LAST && int'(c) < n;
  endfunction
endpackage

// File: rtl/cmd_cfg_multi_if.sv
// cmd_cfg_multi_if: command packet and response handshake between UART side and config block
interface cmd_cfg_multi_if #(parameter int DATA_W = 16);
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data;
  logic [7:0]        resp;
  logic              send_resp;
  logic              resp_sent;
  modport master(output cmd_rdy, cmd, data, resp_sent, input clr_cmd_rdy, resp, send_resp);
  modport slave(input cmd_rdy, cmd, data, resp_sent, output clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/cmd_cfg_multi_wdog_timer.sv
// wdog_timer: saturating link-loss counter emitting a one-cycle trip pulse at timeout
module wdog_timer #(
  parameter int TMO_CYC = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic trip
);
  localparam int W = $clog2(TMO_CYC + 1);
  logic [W-1:0] cnt;
  // Trip on the edge where the count would reach TMO_CYC; a clear in that cycle wins.
  assign trip = en && !clr && cnt == W'(TMO_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || trip) ? '0 : (!en || cnt == W'(TMO_CYC)) ? cnt : cnt + 1'b1;
endmodule

// File: rtl/cmd_cfg_multi.sv
// cmd_cfg_multi: executes command packets, manages setpoints, calibration handshake and link watchdog
module cmd_cfg_multi
  import cmd_cfg_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_SP  = 4,
  parameter int TMO_CYC = 2**20
) (
  input  logic                     clk,
  input  logic                     rst,
  cmd_cfg_multi_if.slave           bus,
  output logic [NUM_SP*DATA_W-1:0] sp,
  output logic                     strt_cal,
  output logic                     inertial_cal,
  input  logic                     cal_done,
  output logic                     motors_off,
  output logic                     wdog_trip
);
  state_t state, nxt;
  logic acc, known, cal_fin, trip, zero;
  assign acc     = state == IDLE && bus.cmd_rdy;
  assign cal_fin = state == CAL_WAIT && cal_done;
  assign known   = is_set(bus.cmd, NUM_SP) || bus.cmd == OP_EMER || bus.cmd == OP_MTRS_OFF;
  assign zero    = trip || (acc && bus.cmd == OP_EMER);
  assign bus.clr_cmd_rdy = acc;
  assign bus.send_resp   = state == RESP;
  assign inertial_cal    = state == CAL_WAIT;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = acc ? (bus.cmd == OP_CAL ? CAL_WAIT : RESP) : IDLE;
      CAL_WAIT:  nxt = cal_done ? RESP : CAL_WAIT;
      RESP:      nxt = WAIT_SENT;
      WAIT_SENT: nxt = bus.resp_sent ? IDLE : WAIT_SENT;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      bus.resp   <= '0;
      strt_cal   <= 1'b0;
      motors_off <= 1'b1;
      wdog_trip  <= 1'b0;
    end else begin
      state      <= nxt;
      strt_cal   <= acc && bus.cmd == OP_CAL;
      bus.resp   <= (acc && bus.cmd != OP_CAL) ? (known ? RESP_ACK : RESP_NAK) : cal_fin ? RESP_ACK : bus.resp;
      motors_off <= (trip || (acc && (bus.cmd == OP_EMER || bus.cmd == OP_MTRS_OFF))) ? 1'b1 : cal_fin ? 1'b0 : motors_off;
      wdog_trip  <= trip ? 1'b1 : cal_fin ? 1'b0 : wdog_trip;
    end
  for (genvar k = 0; k < NUM_SP; k++) begin : g_sp
    logic [DATA_W-1:0] r;
    always_ff @(posedge clk)
      r <= (rst || zero) ? '0 : (acc && bus.cmd == 8'(k)) ? bus.data : r;
    assign sp[k*DATA_W +: DATA_W] = r;
  end
  wdog_timer #(.TMO_CYC(TMO_CYC)) u_wdog (
    .clk (clk),
    .rst (rst),
    .clr (acc || motors_off || state != IDLE),
    .en  (1'b1),
    .trip(trip)
  );
endmodule

// File: tb/tb_cmd_cfg_multi.sv
// tb_cmd_cfg_multi: directed checks of packet execution, calibration, watchdog and reset
module tb_cmd_cfg_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] sp;
  logic        strt_cal, inertial_cal, cal_done = 1'b0, motors_off, wdog_trip;
  int          n_chk = 0, n_fail = 0;
  cmd_cfg_multi_if #(.DATA_W(16)) bus ();
  cmd_cfg_multi #(.DATA_W(16), .NUM_SP(4), .TMO_CYC(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sp(sp), .strt_cal(strt_cal),
    .inertial_cal(inertial_cal), .cal_done(cal_done), .motors_off(motors_off), .wdog_trip(wdog_trip)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // Presents a packet, waits (bounded) for acceptance, returns at +2 of the cycle after acceptance.
  task automatic issue(input logic [7:0] c, input logic [15:0] d);
    bus.cmd_rdy = 1'b1; bus.cmd = c; bus.data = d;
    #1;
    for (int k = 0; k < 100 && !bus.clr_cmd_rdy; k++) begin
      nxt();
      #1;
    end
    chk("clr_seen", bus.clr_cmd_rdy, 1);
    nxt();
    bus.cmd_rdy = 1'b0;
    #1;
    chk("clr_one_cycle", bus.clr_cmd_rdy, 0);
  endtask
  // Called in the send_resp cycle; completes the response and returns on the first IDLE cycle.
  task automatic resp_done(input logic [7:0] r);
    chk("send_resp_hi", bus.send_resp, 1);
    chk("resp", bus.resp, r);
    nxt();
    #1;
    chk("send_resp_lo", bus.send_resp, 0);
    bus.resp_sent = 1'b1;
    nxt();
    bus.resp_sent = 1'b0;
  endtask
  task automatic do_cal(input int n);
    int hi, st;
    hi = 0; st = 0;
    issue(8'h40, 16'h0);
    chk("strt_cal_first", strt_cal, 1);
    for (int i = 1; i <= n; i++) begin
      hi += int'(inertial_cal);
      st += int'(strt_cal);
      cal_done = (i == n);
      nxt();
      #1;
    end
    cal_done = 1'b0;
    chk("strt_cal_pulses", st, 1);
    chk("inertial_cycles", hi, n);
    chk("inertial_lo", inertial_cal, 0);
    chk("cal_motors_on", motors_off, 0);
    chk("cal_trip_clr", wdog_trip, 0);
    resp_done(8'hA5);
  endtask
  initial begin
    bus.cmd_rdy = 1'b0; bus.cmd = '0; bus.data = '0; bus.resp_sent = 1'b0;
    repeat (3) nxt();
    rst = 1'b0;
    #1;
    chk("rst_sp", sp, 64'h0);
    chk("rst_motors_off", motors_off, 1);
    chk("rst_resp", bus.resp, 8'h00);
    chk("rst_send_resp", bus.send_resp, 0);
    chk("rst_strt_cal", strt_cal, 0);
    chk("rst_inertial", inertial_cal, 0);
    chk("rst_clr", bus.clr_cmd_rdy, 0);
    chk("rst_trip", wdog_trip, 0);
    nxt();
    issue(8'h02, 16'h1234);
    chk("set_sp2", sp, 64'h0000_1234_0000_0000);
    resp_done(8'hA5);
    do_cal(10);
    issue(8'h07, 16'hBEEF);
    chk("nak_sp", sp, 64'h0000_1234_0000_0000);
    chk("nak_motors", motors_off, 0);
    resp_done(8'h5A);
    issue(8'h42, 16'hFFFF);
    chk("mtrs_sp", sp, 64'h0000_1234_0000_0000);
    chk("mtrs_motors", motors_off, 1);
    resp_done(8'hA5);
    do_cal(2);
    issue(8'h00, 16'h1111);
    resp_done(8'hA5);
    issue(8'h03, 16'h3333);
    chk("set_sp3", sp, 64'h3333_1234_0000_1111);
    resp_done(8'hA5);
    repeat (31) nxt();
    #1;
    chk("wdog_pre_trip", wdog_trip, 0);
    chk("wdog_pre_sp", sp, 64'h3333_1234_0000_1111);
    nxt();
    #1;
    chk("wdog_trip", wdog_trip, 1);
    chk("wdog_sp", sp, 64'h0);
    chk("wdog_motors", motors_off, 1);
    nxt();
    do_cal(3);
    issue(8'h01, 16'hABCD);
    chk("q_send", bus.send_resp, 1);
    nxt();
    #1;
    chk("q_send_lo", bus.send_resp, 0);
    bus.cmd_rdy = 1'b1; bus.cmd = 8'h00; bus.data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("q_not_cleared", bus.clr_cmd_rdy, 0);
      chk("q_no_resp", bus.send_resp, 0);
      nxt();
    end
    chk("q_held_sp", sp, 64'h0000_0000_ABCD_0000);
    bus.resp_sent = 1'b1;
    nxt();
    bus.resp_sent = 1'b0;
    issue(8'h00, 16'h5555);
    chk("q_exec_sp", sp, 64'h0000_0000_ABCD_5555);
    resp_done(8'hA5);
    issue(8'h41, 16'h0000);
    chk("emer_sp", sp, 64'h0);
    chk("emer_motors", motors_off, 1);
    resp_done(8'hA5);
    issue(8'h02, 16'h2222);
    resp_done(8'hA5);
    issue(8'h40, 16'h0);
    nxt();
    #1;
    chk("pre_rst_inertial", inertial_cal, 1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #1;
    chk("mid_rst_sp", sp, 64'h0);
    chk("mid_rst_inertial", inertial_cal, 0);
    chk("mid_rst_motors", motors_off, 1);
    chk("mid_rst_resp", bus.resp, 8'h00);
    chk("mid_rst_strt", strt_cal, 0);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_resp", bus.send_resp, 0);
      nxt();
      #1;
    end
    cal_done = 1'b1;
    nxt();
    cal_done = 1'b0;
    #1;
    chk("stray_cal_done", motors_off, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
